// File: rtl/evg_sequence_player.sv
// Sequence-event player for the event generator.
// Plays a RAM table of {delay, code} entries as one-cycle TVALID pulses.
// A one-entry prefetch lets zero-delay entries run back to back.
// Code 8'h00 is a silent filler entry. EVCODE_EOS ends playback.
module evg_sequence_player #(
  parameter int unsigned ADDR_WIDTH  = 11,
  parameter int unsigned DELAY_WIDTH = 24,
  parameter logic [7:0]  EVCODE_EOS  = 8'h7F
) (
  input  logic                     evgTxClk,
  input  logic                     evgTxReset,
  input  logic                     tableWE,
  input  logic [ADDR_WIDTH-1:0]    tableWAddr,
  input  logic [DELAY_WIDTH+7:0]   tableWData,
  input  logic                     seqEnable,
  input  logic                     seqTrigger,
  output logic [7:0]               evgSequenceEventTDATA,
  output logic                     evgSequenceEventTVALID,
  output logic                     seqBusy,
  output logic                     seqDone,
  output logic                     seqTriggerIgnored,
  output logic [ADDR_WIDTH-1:0]    seqAddress
);

  localparam int unsigned          DATA_WIDTH = DELAY_WIDTH + 8;
  localparam int unsigned          DEPTH      = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_TWO  = ADDR_WIDTH'(2);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRIME  = 2'd1,
    ST_TIMING = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  // Table storage and read port
  logic [DATA_WIDTH-1:0]  table_mem [DEPTH];
  logic [DATA_WIDTH-1:0]  rd_data_q;
  logic                   rd_en_s;
  logic [ADDR_WIDTH-1:0]  rd_addr_s;
  logic [DELAY_WIDTH-1:0] rd_delay_s;
  logic [7:0]             rd_code_s;

  // Playback state
  state_t                 state_q, state_d;
  logic [DELAY_WIDTH-1:0] cnt_q, cnt_d;
  logic [7:0]             code_q, code_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   tvalid_q, tvalid_d;
  logic [7:0]             tdata_q, tdata_d;
  logic                   done_q, done_d;
  logic                   ign_q, ign_d;
  logic                   busy_q, busy_d;

  assign rd_delay_s = rd_data_q[DATA_WIDTH-1:8];
  assign rd_code_s  = rd_data_q[7:0];

  // Dual-port block RAM: software write port plus synchronous 1-cycle read
  always_ff @(posedge evgTxClk) begin
    if (tableWE) begin
      table_mem[tableWAddr] <= tableWData;
    end
    if (rd_en_s) begin
      rd_data_q <= table_mem[rd_addr_s];
    end
  end

  // Next-state, prefetch and output decode; defaults hold state and idle the outputs
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    code_d    = code_q;
    addr_d    = addr_q;
    tvalid_d  = 1'b0;
    tdata_d   = 8'h00;
    done_d    = 1'b0;
    rd_en_s   = 1'b0;
    rd_addr_s = '0;
    ign_d     = seqEnable && seqTrigger && (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (seqEnable && seqTrigger) begin
          state_d   = ST_PRIME;
          addr_d    = '0;
          rd_en_s   = 1'b1;
          rd_addr_s = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_PRIME: begin
        if (!seqEnable) begin
          state_d = ST_IDLE;
        end else begin
          // Entry 0 becomes current; entry 1 is prefetched
          cnt_d     = rd_delay_s;
          code_d    = rd_code_s;
          rd_en_s   = 1'b1;
          rd_addr_s = ADDR_ONE;
          state_d   = ST_TIMING;
        end
      end

      ST_TIMING: begin
        if (!seqEnable) begin
          // Abort wins over any event due this cycle
          state_d = ST_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DELAY_WIDTH'(1);
        end else if (code_q == EVCODE_EOS) begin
          done_d  = 1'b1;
          state_d = ST_DRAIN;
        end else begin
          if (code_q != 8'h00) begin
            tvalid_d = 1'b1;
            tdata_d  = code_q;
          end else begin
            tvalid_d = 1'b0;
          end
          if (addr_q == LAST_ADDR) begin
            // Last table slot: finish as if a zero-delay EOS followed, address holds
            code_d = EVCODE_EOS;
            cnt_d  = '0;
          end else begin
            // Prefetched entry becomes current; fetch the one after it
            addr_d    = addr_q + ADDR_ONE;
            code_d    = rd_code_s;
            cnt_d     = rd_delay_s;
            rd_en_s   = 1'b1;
            rd_addr_s = addr_q + ADDR_TWO;
          end
        end
      end

      ST_DRAIN: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs, cleared asynchronously by evgTxReset
  always_ff @(posedge evgTxClk or posedge evgTxReset) begin
    if (evgTxReset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      code_q   <= 8'h00;
      addr_q   <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= 8'h00;
      done_q   <= 1'b0;
      ign_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      code_q   <= code_d;
      addr_q   <= addr_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      done_q   <= done_d;
      ign_q    <= ign_d;
      busy_q   <= busy_d;
    end
  end

  assign evgSequenceEventTDATA  = tdata_q;
  assign evgSequenceEventTVALID = tvalid_q;
  assign seqBusy                = busy_q;
  assign seqDone                = done_q;
  assign seqTriggerIgnored      = ign_q;
  assign seqAddress             = addr_q;

endmodule

// File: tb/tb_evg_sequence_player.sv
// Directed bench for evg_sequence_player.
// Instance A uses the default geometry. Instance B uses a 4-entry table
// with 4-bit delays for the end-of-table and maximum-delay cases.
// Log index k is the value seen just after clock edge T+k.
module tb_evg_sequence_player;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A signals
  logic        rst_a, we_a, en_a, trig_a;
  logic [10:0] waddr_a;
  logic [31:0] wdata_a;
  logic [7:0]  data_a;
  logic        valid_a, busy_a, done_a, ign_a;
  logic [10:0] addr_a;

  // Instance B signals
  logic        rst_b, we_b, en_b, trig_b;
  logic [1:0]  waddr_b;
  logic [11:0] wdata_b;
  logic [7:0]  data_b;
  logic        valid_b, busy_b, done_b, ign_b;
  logic [1:0]  addr_b;

  evg_sequence_player dut_a (
    .evgTxClk(clk), .evgTxReset(rst_a), .tableWE(we_a), .tableWAddr(waddr_a),
    .tableWData(wdata_a), .seqEnable(en_a), .seqTrigger(trig_a),
    .evgSequenceEventTDATA(data_a), .evgSequenceEventTVALID(valid_a),
    .seqBusy(busy_a), .seqDone(done_a), .seqTriggerIgnored(ign_a), .seqAddress(addr_a)
  );

  evg_sequence_player #(.ADDR_WIDTH(2), .DELAY_WIDTH(4), .EVCODE_EOS(8'h7F)) dut_b (
    .evgTxClk(clk), .evgTxReset(rst_b), .tableWE(we_b), .tableWAddr(waddr_b),
    .tableWData(wdata_b), .seqEnable(en_b), .seqTrigger(trig_b),
    .evgSequenceEventTDATA(data_b), .evgSequenceEventTVALID(valid_b),
    .seqBusy(busy_b), .seqDone(done_b), .seqTriggerIgnored(ign_b), .seqAddress(addr_b)
  );

  int tests_run = 0;
  int tests_failed = 0;

  logic        v_log    [128];
  logic [7:0]  d_log    [128];
  logic        done_log [128];
  logic        busy_log [128];
  logic        ign_log  [128];
  logic [10:0] a_log    [128];

  // Expected code of the table {5,10},{0,11},{0,12},{3,7F}; 0 means no event
  function automatic logic [7:0] t1_code(input int k);
    case (k)
      7:       return 8'h10;
      8:       return 8'h11;
      9:       return 8'h12;
      default: return 8'h00;
    endcase
  endfunction

  task automatic wr_a(input int addr, input int delay, input logic [7:0] code);
    we_a = 1'b1; waddr_a = addr[10:0]; wdata_a = {delay[23:0], code};
    @(negedge clk);
    we_a = 1'b0;
  endtask

  task automatic wr_b(input int addr, input int delay, input logic [7:0] code);
    we_b = 1'b1; waddr_b = addr[1:0]; wdata_b = {delay[3:0], code};
    @(negedge clk);
    we_b = 1'b0;
  endtask

  task automatic load_t1();
    wr_a(0, 5, 8'h10); wr_a(1, 0, 8'h11); wr_a(2, 0, 8'h12); wr_a(3, 3, 8'h7F);
  endtask

  // Pulse the trigger for one cycle; returns just after the accepting edge T
  task automatic fire(input bit sel_b);
    if (sel_b) trig_b = 1'b1; else trig_a = 1'b1;
    @(negedge clk);
    trig_a = 1'b0; trig_b = 1'b0;
  endtask

  // Log n samples; optional trigger, enable-drop and reset injections on A
  task automatic capture(input bit sel_b, input int n, input int trig_at,
                         input int drop_at, input int rst_at);
    for (int k = 0; k < n; k++) begin
      if (sel_b) begin
        v_log[k] = valid_b; d_log[k] = data_b; done_log[k] = done_b;
        busy_log[k] = busy_b; ign_log[k] = ign_b; a_log[k] = {9'd0, addr_b};
      end else begin
        v_log[k] = valid_a; d_log[k] = data_a; done_log[k] = done_a;
        busy_log[k] = busy_a; ign_log[k] = ign_a; a_log[k] = addr_a;
        trig_a = (k == trig_at);
        if (k == drop_at) en_a = 1'b0;
        if (rst_at >= 0 && k == rst_at) rst_a = 1'b1;
        if (rst_at >= 0 && k == rst_at + 4) rst_a = 1'b0;
      end
      @(negedge clk);
    end
    trig_a = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests_run++;
    if ({data_a, valid_a, busy_a, done_a, ign_a, addr_a} !== 23'd0) begin
      tests_failed++;
      $display("FAIL reset_a got %0h expected 0", {data_a, valid_a, busy_a, done_a, ign_a, addr_a});
    end
    tests_run++;
    if ({data_b, valid_b, busy_b, done_b, ign_b, addr_b} !== 14'd0) begin
      tests_failed++;
      $display("FAIL reset_b got %0h expected 0", {data_b, valid_b, busy_b, done_b, ign_b, addr_b});
    end
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({valid_a, busy_a, done_a, addr_a} !== 14'd0) begin
      tests_failed++;
      $display("FAIL reset_release got %0h expected 0", {valid_a, busy_a, done_a, addr_a});
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ec;
    load_t1(); fire(1'b0); capture(1'b0, 20, -1, -1, -1);
    for (int k = 0; k < 20; k++) begin
      ec = t1_code(k);
      tests_run++;
      if (v_log[k] !== (ec != 8'h00) || (ec != 8'h00 && d_log[k] !== ec)) begin
        tests_failed++;
        $display("FAIL b2b_event k=%0d got v=%0b d=%0h expected v=%0b d=%0h", k, v_log[k], d_log[k], ec != 8'h00, ec);
      end
      tests_run++;
      if (done_log[k] !== (k == 13) || busy_log[k] !== (k <= 13)) begin
        tests_failed++;
        $display("FAIL b2b_done_busy k=%0d got done=%0b busy=%0b expected done=%0b busy=%0b", k, done_log[k], busy_log[k], k == 13, k <= 13);
      end
    end
    tests_run++;
    if (a_log[8] !== 11'd2 || a_log[12] !== 11'd3) begin
      tests_failed++;
      $display("FAIL b2b_address got %0d,%0d expected 2,3", a_log[8], a_log[12]);
    end
  endtask

  task automatic test_filler();
    int nv;
    wr_a(0, 2, 8'h00); wr_a(1, 4, 8'h21); wr_a(2, 0, 8'h7F);
    fire(1'b0); capture(1'b0, 16, -1, -1, -1);
    nv = 0;
    for (int k = 0; k < 16; k++) begin
      if (v_log[k] === 1'b1) nv++;
      tests_run++;
      if (v_log[k] !== (k == 9) || (k == 9 && d_log[k] !== 8'h21) || done_log[k] !== (k == 10)) begin
        tests_failed++;
        $display("FAIL filler k=%0d got v=%0b d=%0h done=%0b expected v=%0b d=21 done=%0b", k, v_log[k], d_log[k], done_log[k], k == 9, k == 10);
      end
    end
    tests_run++;
    if (nv != 1) begin
      tests_failed++;
      $display("FAIL filler_count got %0d expected 1", nv);
    end
  endtask

  task automatic test_trigger_while_busy();
    logic [7:0] ec;
    load_t1(); fire(1'b0); capture(1'b0, 20, 3, -1, -1);
    for (int k = 0; k < 20; k++) begin
      ec = t1_code(k);
      tests_run++;
      if (ign_log[k] !== (k == 4) || v_log[k] !== (ec != 8'h00) || (ec != 8'h00 && d_log[k] !== ec) || done_log[k] !== (k == 13)) begin
        tests_failed++;
        $display("FAIL busy_trig k=%0d got ign=%0b v=%0b d=%0h done=%0b expected ign=%0b v=%0b d=%0h done=%0b", k, ign_log[k], v_log[k], d_log[k], done_log[k], k == 4, ec != 8'h00, ec, k == 13);
      end
    end
  endtask

  task automatic test_enable_low_trigger();
    en_a = 1'b0;
    @(negedge clk);
    fire(1'b0); capture(1'b0, 6, -1, -1, -1);
    for (int k = 0; k < 6; k++) begin
      tests_run++;
      if (busy_log[k] !== 1'b0 || ign_log[k] !== 1'b0) begin
        tests_failed++;
        $display("FAIL en_low_trig k=%0d got busy=%0b ign=%0b expected 0 0", k, busy_log[k], ign_log[k]);
      end
    end
    en_a = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_enable_drop();
    wr_a(0, 100, 8'h30); wr_a(1, 0, 8'h7F);
    fire(1'b0); capture(1'b0, 110, -1, 50, -1);
    for (int k = 0; k < 110; k++) begin
      tests_run++;
      if (busy_log[k] !== (k <= 50) || v_log[k] !== 1'b0 || done_log[k] !== 1'b0) begin
        tests_failed++;
        $display("FAIL en_drop k=%0d got busy=%0b v=%0b done=%0b expected busy=%0b v=0 done=0", k, busy_log[k], v_log[k], done_log[k], k <= 50);
      end
    end
    en_a = 1'b1;
    @(negedge clk);
    fire(1'b0); capture(1'b0, 110, -1, -1, -1);
    for (int k = 0; k < 110; k++) begin
      tests_run++;
      if (v_log[k] !== (k == 102) || (k == 102 && d_log[k] !== 8'h30) || done_log[k] !== (k == 103) || busy_log[k] !== (k <= 103)) begin
        tests_failed++;
        $display("FAIL en_retrig k=%0d got v=%0b d=%0h done=%0b busy=%0b expected v=%0b done=%0b busy=%0b", k, v_log[k], d_log[k], done_log[k], busy_log[k], k == 102, k == 103, k <= 103);
      end
    end
  endtask

  task automatic test_end_of_table();
    logic [7:0] ec;
    int nv;
    wr_b(0, 0, 8'h01); wr_b(1, 0, 8'h02); wr_b(2, 0, 8'h03); wr_b(3, 0, 8'h04);
    fire(1'b1); capture(1'b1, 12, -1, -1, -1);
    nv = 0;
    for (int k = 0; k < 12; k++) begin
      ec = (k >= 2 && k <= 5) ? 8'(k - 1) : 8'h00;
      if (v_log[k] === 1'b1) nv++;
      tests_run++;
      if (v_log[k] !== (ec != 8'h00) || (ec != 8'h00 && d_log[k] !== ec) || done_log[k] !== (k == 6) || busy_log[k] !== (k <= 6)) begin
        tests_failed++;
        $display("FAIL eot k=%0d got v=%0b d=%0h done=%0b busy=%0b expected v=%0b d=%0h done=%0b busy=%0b", k, v_log[k], d_log[k], done_log[k], busy_log[k], ec != 8'h00, ec, k == 6, k <= 6);
      end
    end
    tests_run++;
    if (nv != 4 || a_log[5] !== 11'd3 || a_log[6] !== 11'd3 || a_log[7] !== 11'd3) begin
      tests_failed++;
      $display("FAIL eot_nowrap got count=%0d addr=%0d,%0d,%0d expected 4 and 3,3,3", nv, a_log[5], a_log[6], a_log[7]);
    end
  endtask

  task automatic test_max_delay();
    wr_b(0, 15, 8'h55); wr_b(1, 0, 8'h7F);
    fire(1'b1); capture(1'b1, 22, -1, -1, -1);
    for (int k = 0; k < 22; k++) begin
      tests_run++;
      if (v_log[k] !== (k == 17) || (k == 17 && d_log[k] !== 8'h55) || done_log[k] !== (k == 18)) begin
        tests_failed++;
        $display("FAIL max_delay k=%0d got v=%0b d=%0h done=%0b expected v=%0b d=55 done=%0b", k, v_log[k], d_log[k], done_log[k], k == 17, k == 18);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] ec;
    load_t1(); fire(1'b0); capture(1'b0, 14, -1, -1, 6);
    for (int k = 7; k < 14; k++) begin
      tests_run++;
      if ({d_log[k], v_log[k], busy_log[k], done_log[k], ign_log[k], a_log[k]} !== 23'd0) begin
        tests_failed++;
        $display("FAIL rst_mid k=%0d got %0h expected 0", k, {d_log[k], v_log[k], busy_log[k], done_log[k], ign_log[k], a_log[k]});
      end
    end
    fire(1'b0); capture(1'b0, 20, -1, -1, -1);
    for (int k = 0; k < 20; k++) begin
      ec = t1_code(k);
      tests_run++;
      if (v_log[k] !== (ec != 8'h00) || (ec != 8'h00 && d_log[k] !== ec) || done_log[k] !== (k == 13)) begin
        tests_failed++;
        $display("FAIL rst_replay k=%0d got v=%0b d=%0h done=%0b expected v=%0b d=%0h done=%0b", k, v_log[k], d_log[k], done_log[k], ec != 8'h00, ec, k == 13);
      end
    end
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    we_a = 1'b0; we_b = 1'b0; waddr_a = 11'd0; waddr_b = 2'd0;
    wdata_a = 32'd0; wdata_b = 12'd0;
    en_a = 1'b0; en_b = 1'b0; trig_a = 1'b0; trig_b = 1'b0;
    @(negedge clk);
    test_reset();
    en_a = 1'b1; en_b = 1'b1;
    @(negedge clk);
    test_back_to_back();
    test_filler();
    test_trigger_while_busy();
    test_enable_low_trigger();
    test_enable_drop();
    test_end_of_table();
    test_max_delay();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
